// File: rtl/hex_mux_disp_sync_pkg.sv
// Shared definitions for the multiplexed seven-segment display blocks.
// Holds the segment pattern table, segment bit positions and the pin polarity helper.
package hex_mux_disp_sync_pkg;

    localparam int SEG_G  = 0;
    localparam int SEG_F  = 1;
    localparam int SEG_E  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_C  = 4;
    localparam int SEG_B  = 5;
    localparam int SEG_A  = 6;
    localparam int SEG_DP = 7;

    // Active-low {a,b,c,d,e,f,g} patterns, indexed by the hex value of the digit.
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    function automatic logic apply_polarity(input logic lowLevel, input bit activeLow);
        return activeLow ? lowLevel : ~lowLevel;
    endfunction

endpackage

// File: rtl/hex_sseg_rom_sync.sv
// Synchronous hex-to-segment ROM: the address is registered, the pattern is looked up
// combinationally from the registered address, so the output lags the address by one edge.
module hex_sseg_rom_sync
    import hex_mux_disp_sync_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] addr_i,
    output logic [6:0] seg_o
);

    logic [3:0] addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= 4'h0;
        end else begin
            addr_q <= addr_i;
        end
    end

    assign seg_o = SEG_PATTERNS[addr_q];

endmodule

// File: rtl/hex_mux_disp_sync.sv
// N-digit multiplexed seven-segment driver with a load-gated shadow copy of the display data,
// a per-slot guard interval against ghosting, and registered anode/segment outputs.
module hex_mux_disp_sync
    import hex_mux_disp_sync_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_IDLE   = ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [7:0]          SSEG_IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [N_DIGITS-1:0][3:0] hex_q;
    logic [N_DIGITS-1:0]      dp_q;
    logic [N_DIGITS-1:0]      blank_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [IDX_W-1:0] sel_q;
    logic             dpSel_q;
    logic             off_q;
    logic             off_d;
    logic [3:0]       addr_d;
    logic [6:0]       romSeg;

    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          sseg_q, sseg_d;

    // Shadow copy only moves on load, so a scan never mixes old and new digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q   <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            hex_q   <= hex_in;
            dp_q    <= dp_in;
            blank_q <= blank_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Stage 1: the digit select, dp and darkness flag travel alongside the ROM address register.
    assign addr_d = hex_q[idx_q];
    assign off_d  = blank_q[idx_q] | (int'(cnt_q) < GUARD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q   <= '0;
            dpSel_q <= 1'b0;
            off_q   <= 1'b1;
        end else begin
            sel_q   <= idx_q;
            dpSel_q <= dp_q[idx_q];
            off_q   <= off_d;
        end
    end

    hex_sseg_rom_sync u_rom (
        .clk    (clk),
        .reset  (reset),
        .addr_i (addr_d),
        .seg_o  (romSeg)
    );

    // Stage 2 is built active-low first, then mapped to the pin polarity bit by bit.
    always_comb begin
        logic [N_DIGITS-1:0] anLow;
        logic [7:0]          ssegLow;
        anLow   = {N_DIGITS{1'b1}};
        ssegLow = 8'hFF;
        if (!off_q) begin
            anLow                = ~(N_DIGITS'(1) << sel_q);
            ssegLow[SEG_DP]      = ~dpSel_q;
            ssegLow[SEG_A:SEG_G] = romSeg;
        end
        an_d   = '0;
        sseg_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = apply_polarity(anLow[i], ACTIVE_LOW);
        end
        for (int i = 0; i < 8; i++) begin
            sseg_d[i] = apply_polarity(ssegLow[i], ACTIVE_LOW);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q   <= AN_IDLE;
            sseg_q <= SSEG_IDLE;
        end else begin
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_hex_mux_disp_sync.sv
// Directed bench for hex_mux_disp_sync with N_DIGITS=4, PRESCALE=8, GUARD=1; one instance per polarity.
// Scan phase is tracked by counting edges since reset release: outputs after edge n show t = n-2.
module tb_hex_mux_disp_sync;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] hexIn;
    logic [3:0]  dpIn;
    logic [3:0]  blankIn;
    logic [3:0]  anLow, anHigh;
    logic [7:0]  ssegLow, ssegHigh;

    int testsRun;
    int testsFailed;
    int edgeN;

    hex_mux_disp_sync #(.N_DIGITS(4), .PRESCALE(8), .GUARD(1), .ACTIVE_LOW(1'b1)) dutLow (
        .clk(clk), .reset(reset), .load(load), .hex_in(hexIn), .dp_in(dpIn),
        .blank_in(blankIn), .an(anLow), .sseg(ssegLow)
    );

    hex_mux_disp_sync #(.N_DIGITS(4), .PRESCALE(8), .GUARD(1), .ACTIVE_LOW(1'b0)) dutHigh (
        .clk(clk), .reset(reset), .load(load), .hex_in(hexIn), .dp_in(dpIn),
        .blank_in(blankIn), .an(anHigh), .sseg(ssegHigh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edgeN++;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        edgeN = 0;
    endtask

    task automatic goto_phase(input int d, input int c);
        int budget;
        budget = 0;
        while (!(edgeN >= 2 && (((edgeN - 2) / 8) % 4) == d && ((edgeN - 2) % 8) == c) && budget < 80) begin
            step();
            budget++;
        end
        if (budget >= 80) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL goto_phase: phase d%0d c%0d not reached within %0d cycles", d, c, budget);
        end
    endtask

    task automatic load_data(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
        hexIn   = h;
        dpIn    = dp;
        blankIn = bl;
        load    = 1'b1;
        step();
        load    = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        testsRun++;
        if (anLow !== 4'hF) begin testsFailed++; $display("[TB] FAIL reset_an_low: got %b want 1111", anLow); end
        testsRun++;
        if (ssegLow !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_sseg_low: got %h want ff", ssegLow); end
        testsRun++;
        if (anHigh !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_an_high: got %b want 0000", anHigh); end
        testsRun++;
        if (ssegHigh !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_sseg_high: got %h want 00", ssegHigh); end
        repeat (2) @(posedge clk);
        release_reset();
        step();
        step();
        testsRun++;
        if (anLow !== 4'b1111) begin testsFailed++; $display("[TB] FAIL release_edge2_an: got %b want 1111", anLow); end
        step();
        testsRun++;
        if (anLow !== 4'b1110) begin testsFailed++; $display("[TB] FAIL release_edge3_an: got %b want 1110", anLow); end
        testsRun++;
        if (ssegLow !== 8'h81) begin testsFailed++; $display("[TB] FAIL release_edge3_sseg: got %h want 81", ssegLow); end
        testsRun++;
        if (anHigh !== 4'b0001) begin testsFailed++; $display("[TB] FAIL high_pol_an: got %b want 0001", anHigh); end
        testsRun++;
        if (ssegHigh !== 8'h7E) begin testsFailed++; $display("[TB] FAIL high_pol_sseg: got %h want 7e", ssegHigh); end
        for (int i = 0; i < 6; i++) begin
            step();
            testsRun++;
            if (anLow !== 4'b1110) begin testsFailed++; $display("[TB] FAIL d0_lit_window[%0d]: got %b want 1110", i, anLow); end
        end
        step();
        testsRun++;
        if (anLow !== 4'b1111) begin testsFailed++; $display("[TB] FAIL guard_before_d1: got %b want 1111", anLow); end
        step();
        testsRun++;
        if (anLow !== 4'b1101) begin testsFailed++; $display("[TB] FAIL d1_first_lit: got %b want 1101", anLow); end
        testsRun++;
        if (ssegLow !== 8'h81) begin testsFailed++; $display("[TB] FAIL d1_first_sseg: got %h want 81", ssegLow); end
    endtask

    task automatic test_scan_values();
        logic [7:0] expSeg [4];
        logic [3:0] expAn;
        expSeg = '{8'hB8, 8'hA4, 8'h88, 8'h86};
        load_data(16'h3A5F, 4'b0000, 4'b0000);
        for (int d = 0; d < 4; d++) begin
            goto_phase(d, 4);
            expAn    = 4'hF;
            expAn[d] = 1'b0;
            testsRun++;
            if (anLow !== expAn) begin testsFailed++; $display("[TB] FAIL scan_an_d%0d: got %b want %b", d, anLow, expAn); end
            testsRun++;
            if (ssegLow !== expSeg[d]) begin testsFailed++; $display("[TB] FAIL scan_sseg_d%0d: got %h want %h", d, ssegLow, expSeg[d]); end
        end
        goto_phase(0, 0);
        testsRun++;
        if (anLow !== 4'b1111) begin testsFailed++; $display("[TB] FAIL scan_guard_d0: got %b want 1111", anLow); end
    endtask

    task automatic test_dp_blank();
        load_data(16'h3A5F, 4'b0100, 4'b1000);
        goto_phase(2, 3);
        testsRun++;
        if (anLow !== 4'b1011) begin testsFailed++; $display("[TB] FAIL dp_an_d2: got %b want 1011", anLow); end
        testsRun++;
        if (ssegLow !== 8'h08) begin testsFailed++; $display("[TB] FAIL dp_sseg_d2: got %h want 08", ssegLow); end
        goto_phase(3, 0);
        for (int c = 0; c < 8; c++) begin
            testsRun++;
            if (anLow !== 4'b1111) begin testsFailed++; $display("[TB] FAIL blank_an_d3_c%0d: got %b want 1111", c, anLow); end
            testsRun++;
            if (ssegLow !== 8'hFF) begin testsFailed++; $display("[TB] FAIL blank_sseg_d3_c%0d: got %h want ff", c, ssegLow); end
            step();
        end
        goto_phase(0, 2);
        testsRun++;
        if (ssegLow !== 8'hB8) begin testsFailed++; $display("[TB] FAIL dp_only_d2_d0: got %h want b8", ssegLow); end
    endtask

    task automatic test_back_to_back();
        load_data(16'h3A5F, 4'b0000, 4'b0000);
        hexIn = 16'h1234;
        goto_phase(0, 4);
        testsRun++;
        if (ssegLow !== 8'hB8) begin testsFailed++; $display("[TB] FAIL noload_d0: got %h want b8", ssegLow); end
        goto_phase(1, 4);
        testsRun++;
        if (ssegLow !== 8'hA4) begin testsFailed++; $display("[TB] FAIL noload_d1: got %h want a4", ssegLow); end
        goto_phase(0, 5);
        load = 1'b1;
        step();
        load = 1'b0;
        testsRun++;
        if (ssegLow !== 8'hB8) begin testsFailed++; $display("[TB] FAIL wrap_c6_old: got %h want b8", ssegLow); end
        step();
        testsRun++;
        if (ssegLow !== 8'hB8) begin testsFailed++; $display("[TB] FAIL wrap_c7_old: got %h want b8", ssegLow); end
        step();
        testsRun++;
        if (anLow !== 4'b1111) begin testsFailed++; $display("[TB] FAIL wrap_guard: got %b want 1111", anLow); end
        step();
        testsRun++;
        if (anLow !== 4'b1101) begin testsFailed++; $display("[TB] FAIL wrap_new_an: got %b want 1101", anLow); end
        testsRun++;
        if (ssegLow !== 8'h86) begin testsFailed++; $display("[TB] FAIL wrap_new_sseg: got %h want 86", ssegLow); end
        goto_phase(2, 3);
        testsRun++;
        if (ssegLow !== 8'h92) begin testsFailed++; $display("[TB] FAIL new_d2: got %h want 92", ssegLow); end
        goto_phase(0, 3);
        testsRun++;
        if (ssegLow !== 8'hCC) begin testsFailed++; $display("[TB] FAIL new_d0: got %h want cc", ssegLow); end
    endtask

    task automatic test_reset_midslot();
        goto_phase(2, 3);
        #2;
        reset = 1'b1;
        #1;
        testsRun++;
        if (anLow !== 4'hF) begin testsFailed++; $display("[TB] FAIL mid_reset_an: got %b want 1111", anLow); end
        testsRun++;
        if (ssegLow !== 8'hFF) begin testsFailed++; $display("[TB] FAIL mid_reset_sseg: got %h want ff", ssegLow); end
        testsRun++;
        if (anHigh !== 4'h0) begin testsFailed++; $display("[TB] FAIL mid_reset_an_high: got %b want 0000", anHigh); end
        release_reset();
        step();
        step();
        testsRun++;
        if (anLow !== 4'b1111) begin testsFailed++; $display("[TB] FAIL restart_guard: got %b want 1111", anLow); end
        step();
        testsRun++;
        if (anLow !== 4'b1110) begin testsFailed++; $display("[TB] FAIL restart_d0_an: got %b want 1110", anLow); end
        testsRun++;
        if (ssegLow !== 8'h81) begin testsFailed++; $display("[TB] FAIL restart_d0_sseg: got %h want 81", ssegLow); end
        testsRun++;
        if (ssegHigh !== 8'h7E) begin testsFailed++; $display("[TB] FAIL restart_high_sseg: got %h want 7e", ssegHigh); end
        goto_phase(1, 3);
        testsRun++;
        if (ssegLow !== 8'h81) begin testsFailed++; $display("[TB] FAIL restart_d1_sseg: got %h want 81", ssegLow); end
        goto_phase(3, 3);
        testsRun++;
        if (anLow !== 4'b0111) begin testsFailed++; $display("[TB] FAIL restart_d3_an: got %b want 0111", anLow); end
        testsRun++;
        if (ssegLow !== 8'h81) begin testsFailed++; $display("[TB] FAIL restart_d3_sseg: got %h want 81", ssegLow); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        edgeN       = 0;
        reset       = 1'b1;
        load        = 1'b0;
        hexIn       = 16'h0000;
        dpIn        = 4'b0000;
        blankIn     = 4'b0000;
        test_reset();
        test_scan_values();
        test_dp_blank();
        test_back_to_back();
        test_reset_midslot();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
